// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: reset PC, instruction
// field positions, fetch FSM encodings and the buffered entry layout.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous instruction buffer of {pc, instr} entries; flush outranks push/pop.
module fetch_unit_fifo
   import fetch_unit_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  din,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Storage is cleared on reset so the head outputs read zero out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word read at a time and
// buffers returned words for decode; a redirect flushes buffered and in-flight fetches.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   fetch_unit_if.master       bus,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [31:0]        instr,
   output logic [31:0]        instr_pc,
   output logic [5:0]         OpCode,
   output logic [5:0]         Funct
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state;
   fetch_state_t  state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_nxt;
   logic [31:0]   pending_pc;
   logic          pending_ld;
   logic          ack_fire;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   fetch_entry_t  din;
   fetch_entry_t  head;

   assign bus.imem_req  = (state == REQ) || (state == DRAIN);
   assign bus.imem_addr = fetch_pc;

   assign ack_fire  = bus.imem_req && bus.imem_ack;
   assign pop       = instr_ready && !fifo_empty && !redirect;
   assign push      = (state == REQ) && ack_fire && !redirect && !fifo_full;
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign din       = '{pc: fetch_pc, instr: bus.imem_rdata};

   fetch_unit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   (din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count),
      .head  (head)
   );

   // A redirect that catches a request still waiting for its ack must let that
   // ack drain first, so the new target is parked in pending_pc meanwhile.
   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      pending_ld   = 1'b0;
      if (redirect) begin
         if ((state != IDLE) && !ack_fire) begin
            pending_ld = 1'b1;
            state_nxt  = DRAIN;
         end else begin
            fetch_pc_nxt = align_pc(redirect_pc);
            state_nxt    = REQ;
         end
      end else begin
         case (state)
            IDLE: begin
               if (count_nxt < CW'(FIFO_DEPTH)) state_nxt = REQ;
            end
            REQ: begin
               if (ack_fire) begin
                  fetch_pc_nxt = fetch_pc + 32'd4;
                  state_nxt    = (count_nxt < CW'(FIFO_DEPTH)) ? REQ : IDLE;
               end
            end
            DRAIN: begin
               if (ack_fire) begin
                  fetch_pc_nxt = pending_pc;
                  state_nxt    = REQ;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (pending_ld) pending_pc <= align_pc(redirect_pc);
   end

   assign instr_valid = !fifo_empty;
   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign OpCode      = head.instr[OP_HI:OP_LO];
   assign Funct       = head.instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model with programmable ack delay feeds
// a scoreboard queue that is checked against every instruction decode consumes.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [5:0]  OpCode;
   logic [5:0]  Funct;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_3000), .FIFO_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .OpCode      (OpCode),
      .Funct       (Funct)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   int           ack_delay = 0;
   int           wait_cnt = 0;
   bit           stale = 1'b0;
   logic [31:0]  exp_addr = 32'h0000_3000;
   fetch_entry_t q [$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h0085_1020;
      return a * 32'h9E37_79B1 + 32'h0000_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory response, check this cycle, update model, advance.
   task automatic step();
      fetch_entry_t e;
      bit           acked;
      bus.imem_ack   = bus.imem_req && (wait_cnt >= ack_delay);
      bus.imem_rdata = bus.imem_ack ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
      acked = bus.imem_ack;
      #1;
      chk("valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
      if (bus.imem_req && !stale) chk("addr", bus.imem_addr, exp_addr);
      if (instr_valid && instr_ready && !redirect && q.size() != 0) begin
         e = q.pop_front();
         chk("instr", instr, e.instr);
         chk("instr_pc", instr_pc, e.pc);
         chk("opcode", {26'd0, OpCode}, {26'd0, e.instr[31:26]});
         chk("funct", {26'd0, Funct}, {26'd0, e.instr[5:0]});
      end
      if (bus.imem_req && acked) begin
         if (!redirect && !stale) begin
            q.push_back('{pc: bus.imem_addr, instr: bus.imem_rdata});
            exp_addr = exp_addr + 32'd4;
         end
         stale    = 1'b0;
         wait_cnt = 0;
      end else if (bus.imem_req) begin
         wait_cnt++;
      end
      if (redirect) begin
         q.delete();
         exp_addr = redirect_pc & 32'hFFFF_FFFC;
         if (bus.imem_req && !acked) stale = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      redirect = 1'b0;
   endtask

   initial begin
      logic [31:0] held;
      bit          found;
      rst            = 1'b1;
      redirect       = 1'b0;
      redirect_pc    = 32'd0;
      instr_ready    = 1'b1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'd0;

      @(negedge clk);
      #1;
      chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst_addr", bus.imem_addr, 32'h0000_3000);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", instr_pc, 32'd0);
      chk("rst_fields", {20'd0, OpCode, Funct}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back fetch with immediate acks and decode always ready
      chk("t1_idle", {31'd0, bus.imem_req}, 32'd0);
      step();
      chk("t1_addr0", bus.imem_addr, 32'h0000_3000);
      chk("t1_req0", {31'd0, bus.imem_req}, 32'd1);
      step();
      chk("t1_addr1", bus.imem_addr, 32'h0000_3004);
      chk("t1_vld", {31'd0, instr_valid}, 32'd1);
      chk("t1_pc", instr_pc, 32'h0000_3000);
      chk("t1_op", {26'd0, OpCode}, 32'h00);
      chk("t1_fn", {26'd0, Funct}, 32'h20);
      step();
      chk("t1_addr2", bus.imem_addr, 32'h0000_3008);
      for (int i = 0; i < 3; i++) step();

      // Decode stalls: buffer fills and requests stop
      instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("t2_idle", {31'd0, bus.imem_req}, 32'd0);
      chk("t2_full_vld", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
      step();
      chk("t2_resume", {31'd0, bus.imem_req}, 32'd1);

      // Slow memory: request and address held while waiting
      ack_delay = 3;
      held = bus.imem_addr;
      for (int i = 0; i < 4; i++) begin
         chk("t3_req_held", {31'd0, bus.imem_req}, 32'd1);
         chk("t3_addr_held", bus.imem_addr, held);
         step();
      end
      chk("t3_vld", {31'd0, instr_valid}, 32'd1);
      chk("t3_pc", instr_pc, held);

      // Redirect while a request is outstanding
      held = bus.imem_addr;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_3104;
      step();
      chk("t4_flushed", {31'd0, instr_valid}, 32'd0);
      chk("t4_drain_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t4_drain_addr", bus.imem_addr, held);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (bus.imem_req && bus.imem_addr == 32'h0000_3104) found = 1'b1;
         else step();
      end
      chk("t4_new_addr_seen", {31'd0, found}, 32'd1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1'b1;
         else step();
      end
      chk("t4_vld_seen", {31'd0, found}, 32'd1);
      chk("t4_pc", instr_pc, 32'h0000_3104);

      // Redirect coinciding with ack and pop, unaligned target
      ack_delay = 0;
      for (int i = 0; i < 3; i++) step();
      chk("t5_pre_vld", {31'd0, instr_valid}, 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_3203;
      step();
      chk("t5_flushed", {31'd0, instr_valid}, 32'd0);
      chk("t5_addr", bus.imem_addr, 32'h0000_3200);
      step();
      chk("t5_pc", instr_pc, 32'h0000_3200);

      // PC wraps around the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step();
      chk("t6_top", bus.imem_addr, 32'hFFFF_FFFC);
      step();
      chk("t6_wrap", bus.imem_addr, 32'h0000_0000);

      // Asynchronous reset in the middle of a drain
      ack_delay   = 3;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_5000;
      step();
      chk("t6_drain_req", {31'd0, bus.imem_req}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_req", {31'd0, bus.imem_req}, 32'd0);
      chk("t6_rst_vld", {31'd0, instr_valid}, 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      q.delete();
      stale     = 1'b0;
      wait_cnt  = 0;
      ack_delay = 0;
      exp_addr  = 32'h0000_3000;
      step();
      chk("t6_post_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t6_post_addr", bus.imem_addr, 32'h0000_3000);
      for (int i = 0; i < 3; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
